phase_accumulator_nco: RTL and testbench
========================================

// Module: phase_accumulator_nco
// PURPOSE
//   Numerically controlled oscillator front end: generates the 8-bit phase word consumed by the
//   quarter-wave sine lookup, one new phase per audio sample tick. Pitch is set by a tuning word
//   loaded over a valid/ready handshake. The new word is applied glitch-free at the waveform wrap.
//   It sits between the note/pitch controller (upstream) and the sine lookup and output DAC path.
// PARAMETERS
//   ACC_WIDTH       24  accumulator and tuning-word width in bits (>= PHASE_WIDTH+1)
//   PHASE_WIDTH      8  output phase width: top PHASE_WIDTH bits of the accumulator
//   UPDATE_AT_WRAP   1  1: pending tuning word applied at wrap; 0: applied on next sample_tick
// PORTS
//   clk          in   1                system clock; all state on rising edge
//   rst_n        in   1                asynchronous, active-low reset
//   sample_tick  in   1                one-cycle strobe at the audio sample rate
//   enable       in   1                1: accumulate on ticks; 0: ticks ignored, phase held
//   sync         in   1                hard-sync strobe: zero the accumulator
//   tw_data      in   ACC_WIDTH        tuning word (phase increment per tick)
//   tw_valid     in   1                tw_data offered
//   tw_ready     out  1                pending slot empty, word accepted when valid&&ready
//   phase        out  PHASE_WIDTH      acc[ACC_WIDTH-1 -: PHASE_WIDTH], registered
//   phase_valid  out  1                one-cycle pulse: phase updated this cycle
//   wrap         out  1                one-cycle pulse with phase_valid: new waveform cycle
// BEHAVIOUR
//   Reset: acc=0, tw_active=0, pending EMPTY, phase=0, phase_valid=0, wrap=0, tw_ready=1.
//   Pending FSM: EMPTY --(tw_valid&&tw_ready)--> FULL (tw_pending<=tw_data); FULL --apply--> EMPTY.
//     tw_ready = (state==EMPTY), registered. A word accepted in cycle N is eligible from N+1.
//   Apply condition (state FULL at cycle start):
//     UPDATE_AT_WRAP=1: on a sample_tick whose add carries out; the old word is used for that add,
//       the new word for the next tick. Also applied immediately (no tick needed) when enable=0,
//       when tw_active==0 (would never wrap), or on sync.
//     UPDATE_AT_WRAP=0: on the next sample_tick; the new word is used for that same add.
//   Tick (sample_tick&&enable&&!sync): {carry,acc} <= acc + tw_active, modulo 2^ACC_WIDTH.
//     Next cycle: phase=new top bits, phase_valid=1, wrap=carry. Latency tick->phase = 1 cycle.
//   sync (priority over tick): acc<=0, phase<=0. With a coincident enabled tick: phase_valid=1,
//     wrap=1. Without one: phase_valid=0, wrap=0. A pending word is applied on sync.
//   enable=0: acc/phase held, phase_valid=0; sync still zeroes; handshake still works.
//   tw_active=0 with ticks: phase_valid pulses, phase constant, wrap=0.
//   tw_active >= 2^(ACC_WIDTH-1): legal (aliasing); wrap = carry, no special case.
//   Async reset mid-operation: all state to reset values at once, pending word discarded.
//   phase_valid/wrap are never high for more than one consecutive cycle unless ticks are back-to-back.
// STRUCTURE
//   Package synth_osc_pkg: ACC_WIDTH/PHASE_WIDTH defaults, tuning_word_t, pending-state encoding
//     (PEND_EMPTY, PEND_FULL).
//   Sub-module tuning_word_buffer: pending register, FSM, tw_ready and the apply-request logic.
//     Top level: accumulator, carry, sync/enable priority, output registers.
// TESTING (ACC_WIDTH=24, PHASE_WIDTH=8, tick every 4 clocks unless stated)
//   1 Reset: assert rst_n=0 mid-run -> phase=0, phase_valid=0, wrap=0, tw_ready=1 asynchronously.
//   2 Load tw=0x010000, 256 ticks -> phase 1,2,...,255,0 each 1 cycle after tick; wrap only on 0.
//   3 UPDATE_AT_WRAP=1: at phase 0x80 load tw=0x020000 -> tw_ready=0; steps stay 1 until wrap,
//     then steps of 2 (0x02,0x04...); tw_ready=1 cycle after apply; 2nd offer stalls until then.
//   4 UPDATE_AT_WRAP=0: same load -> step of 2 on the very next tick.
//   5 sync with tick at phase 0x37 -> phase=0, phase_valid=1, wrap=1; sync without tick -> phase=0,
//     phase_valid=0; sync with pending FULL -> tw_ready returns 1.
//   6 enable=0 for 10 ticks -> phase held, no phase_valid; tw_active=0 + ticks -> wrap never.

Source files
------------

// File: rtl/synth_osc_pkg.sv
// rtl/synth_osc_pkg.sv - shared widths, tuning-word type and pending-slot encoding for the NCO
package synth_osc_pkg;

    localparam int ACC_WIDTH_DEF   = 24;
    localparam int PHASE_WIDTH_DEF = 8;

    typedef logic [ACC_WIDTH_DEF-1:0] tuning_word_t;

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_t;

endpackage

// File: rtl/tuning_word_buffer.sv
// rtl/tuning_word_buffer.sv - one-deep pending tuning-word slot with handshake and apply decision
module tuning_word_buffer
    import synth_osc_pkg::*;
#(
    parameter int ACC_WIDTH      = ACC_WIDTH_DEF,
    parameter int UPDATE_AT_WRAP = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [ACC_WIDTH-1:0] i_tw_data,
    input  logic                 i_tw_valid,
    output logic                 o_tw_ready,
    input  logic                 i_tick,
    input  logic                 i_enable,
    input  logic                 i_sync,
    input  logic                 i_carry,
    input  logic                 i_active_zero,
    output logic                 o_apply,
    output logic [ACC_WIDTH-1:0] o_tw_pending
);

    pend_state_t          r_state;
    pend_state_t          w_state_next;
    logic [ACC_WIDTH-1:0] r_tw_pending;
    logic                 w_apply_cond;
    logic                 w_load;
    logic                 w_apply;

    // At-wrap mode also releases the word whenever a wrap can never arrive (idle, zero step, sync).
    generate
        if (UPDATE_AT_WRAP != 0) begin : g_at_wrap
            assign w_apply_cond = (i_tick && i_carry) || !i_enable || i_active_zero || i_sync;
        end else begin : g_at_tick
            assign w_apply_cond = i_tick || i_sync;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= PEND_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_apply      = 1'b0;
        case (r_state)
            PEND_EMPTY: begin
                if (i_tw_valid) begin
                    w_load       = 1'b1;
                    w_state_next = PEND_FULL;
                end
            end
            PEND_FULL: begin
                if (w_apply_cond) begin
                    w_apply      = 1'b1;
                    w_state_next = PEND_EMPTY;
                end
            end
            default: w_state_next = PEND_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tw_pending <= '0;
        end else if (w_load) begin
            r_tw_pending <= i_tw_data;
        end
    end

    assign o_tw_ready   = (r_state == PEND_EMPTY);
    assign o_apply      = w_apply;
    assign o_tw_pending = r_tw_pending;

endmodule

// File: rtl/phase_accumulator_nco.sv
// rtl/phase_accumulator_nco.sv - NCO phase accumulator: tick-driven add, hard sync, registered phase/wrap
module phase_accumulator_nco
    import synth_osc_pkg::*;
#(
    parameter int ACC_WIDTH      = ACC_WIDTH_DEF,
    parameter int PHASE_WIDTH    = PHASE_WIDTH_DEF,
    parameter int UPDATE_AT_WRAP = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_sample_tick,
    input  logic                   i_enable,
    input  logic                   i_sync,
    input  logic [ACC_WIDTH-1:0]   i_tw_data,
    input  logic                   i_tw_valid,
    output logic                   o_tw_ready,
    output logic [PHASE_WIDTH-1:0] o_phase,
    output logic                   o_phase_valid,
    output logic                   o_wrap
);

    logic [ACC_WIDTH-1:0]   r_acc;
    logic [ACC_WIDTH-1:0]   r_tw_active;
    logic [PHASE_WIDTH-1:0] r_phase;
    logic                   r_phase_valid;
    logic                   r_wrap;

    logic                   w_tick;
    logic                   w_sync_tick;
    logic [ACC_WIDTH-1:0]   w_inc;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_carry;
    logic                   w_apply;
    logic [ACC_WIDTH-1:0]   w_tw_pending;

    assign w_tick      = i_sample_tick && i_enable && !i_sync;
    assign w_sync_tick = i_sample_tick && i_enable;

    // At-tick mode adds the freshly applied word on the same tick; at-wrap mode always adds the old one.
    generate
        if (UPDATE_AT_WRAP != 0) begin : g_inc_active
            assign w_inc = r_tw_active;
        end else begin : g_inc_pending
            assign w_inc = w_apply ? w_tw_pending : r_tw_active;
        end
    endgenerate

    assign w_sum   = {1'b0, r_acc} + {1'b0, w_inc};
    assign w_carry = w_sum[ACC_WIDTH];

    tuning_word_buffer #(
        .ACC_WIDTH      (ACC_WIDTH),
        .UPDATE_AT_WRAP (UPDATE_AT_WRAP)
    ) u_tw_buf (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_tw_data     (i_tw_data),
        .i_tw_valid    (i_tw_valid),
        .o_tw_ready    (o_tw_ready),
        .i_tick        (w_tick),
        .i_enable      (i_enable),
        .i_sync        (i_sync),
        .i_carry       (w_carry),
        .i_active_zero (r_tw_active == '0),
        .o_apply       (w_apply),
        .o_tw_pending  (w_tw_pending)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tw_active <= '0;
        end else if (w_apply) begin
            r_tw_active <= w_tw_pending;
        end
    end

    // Sync outranks a tick; a tick coinciding with sync is reported as a fresh waveform cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc         <= '0;
            r_phase       <= '0;
            r_phase_valid <= 1'b0;
            r_wrap        <= 1'b0;
        end else if (i_sync) begin
            r_acc         <= '0;
            r_phase       <= '0;
            r_phase_valid <= w_sync_tick;
            r_wrap        <= w_sync_tick;
        end else if (w_tick) begin
            r_acc         <= w_sum[ACC_WIDTH-1:0];
            r_phase       <= w_sum[ACC_WIDTH-1 -: PHASE_WIDTH];
            r_phase_valid <= 1'b1;
            r_wrap        <= w_carry;
        end else begin
            r_phase_valid <= 1'b0;
            r_wrap        <= 1'b0;
        end
    end

    assign o_phase       = r_phase;
    assign o_phase_valid = r_phase_valid;
    assign o_wrap        = r_wrap;

endmodule

// File: tb/tb_phase_accumulator_nco.sv
// tb/tb_phase_accumulator_nco.sv - self-checking bench for phase_accumulator_nco in both update modes
module tb_phase_accumulator_nco;
    import synth_osc_pkg::*;

    localparam longint MODV = 64'h100_0000;
    localparam int     SHR  = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tick = 1'b0, en = 1'b1, sync_s = 1'b0, va = 1'b0, vb = 1'b0;
    tuning_word_t data = '0;
    logic         ra, pva, wa, rb, pvb, wb;
    logic [7:0]   pa, pb;

    always #5 clk = ~clk;

    phase_accumulator_nco #(.ACC_WIDTH(24), .PHASE_WIDTH(8), .UPDATE_AT_WRAP(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_tick(tick), .i_enable(en), .i_sync(sync_s),
        .i_tw_data(data), .i_tw_valid(va), .o_tw_ready(ra), .o_phase(pa),
        .o_phase_valid(pva), .o_wrap(wa));

    phase_accumulator_nco #(.ACC_WIDTH(24), .PHASE_WIDTH(8), .UPDATE_AT_WRAP(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_tick(tick), .i_enable(en), .i_sync(sync_s),
        .i_tw_data(data), .i_tw_valid(vb), .o_tw_ready(rb), .o_phase(pb),
        .o_phase_valid(pvb), .o_wrap(wb));

    typedef struct {
        longint acc;
        longint active;
        longint pend;
        bit     full;
        int     phase;
        bit     pv;
        bit     wrap;
    } mdl_t;

    typedef struct {
        bit     tick;
        bit     en;
        bit     sync;
        bit     valid;
        longint data;
        int     ph;
        bit     pv;
        bit     wr;
        bit     rdy;
    } vec_t;

    mdl_t ma, mb;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vt[14];

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.acc = 0; z.active = 0; z.pend = 0; z.full = 0; z.phase = 0; z.pv = 0; z.wrap = 0;
        return z;
    endfunction

    // Reference behaviour of one clock edge, from the pitch-update rules.
    function automatic mdl_t step(mdl_t m, bit at_wrap, bit t, bit e, bit s, bit v, longint d);
        mdl_t   n = m;
        bit     adds = t && e && !s;
        longint inc = m.active;
        longint total;
        bit     apply;
        if (at_wrap) begin
            apply = m.full && ((adds && (m.acc + m.active >= MODV)) || !e || m.active == 0 || s);
        end else begin
            apply = m.full && (adds || s);
            if (apply) inc = m.pend;
        end
        total = m.acc + inc;
        if (s) begin
            n.acc = 0; n.phase = 0; n.pv = t && e; n.wrap = t && e;
        end else if (adds) begin
            n.acc = total % MODV; n.phase = int'(n.acc >> SHR); n.pv = 1; n.wrap = (total >= MODV);
        end else begin
            n.pv = 0; n.wrap = 0;
        end
        if (apply) begin
            n.active = m.pend; n.full = 0;
        end else if (!m.full && v) begin
            n.pend = d; n.full = 1;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a_phase", 64'(pa), 64'(ma.phase));
        check("a_phase_valid", 64'(pva), 64'(ma.pv));
        check("a_wrap", 64'(wa), 64'(ma.wrap));
        check("a_tw_ready", 64'(ra), 64'(!ma.full));
        check("b_phase", 64'(pb), 64'(mb.phase));
        check("b_phase_valid", 64'(pvb), 64'(mb.pv));
        check("b_wrap", 64'(wb), 64'(mb.wrap));
        check("b_tw_ready", 64'(rb), 64'(!mb.full));
    endtask

    task automatic cycle();
        mdl_t na, nb;
        na = step(ma, 1'b1, tick, en, sync_s, va, longint'(data));
        nb = step(mb, 1'b0, tick, en, sync_s, vb, longint'(data));
        @(posedge clk);
        #1;
        ma = na;
        mb = nb;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic tick_once();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        ma = mdl_zero();
        mb = mdl_zero();
        compare_all();
        tick = 0; en = 1; sync_s = 0; va = 0; vb = 0; data = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic load_both(input longint w);
        va = 1; vb = 1; data = 24'(w);
        cycle();
        va = 0; vb = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        vt[0]  = '{0, 1, 0, 1, 64'h010000, 8'h00, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 0, 0,          8'h00, 0, 0, 1};
        vt[2]  = '{1, 1, 0, 0, 0,          8'h01, 1, 0, 1};
        vt[3]  = '{0, 1, 0, 0, 0,          8'h01, 0, 0, 1};
        vt[4]  = '{1, 1, 0, 0, 0,          8'h02, 1, 0, 1};
        vt[5]  = '{1, 1, 1, 0, 0,          8'h00, 1, 1, 1};
        vt[6]  = '{0, 1, 1, 0, 0,          8'h00, 0, 0, 1};
        vt[7]  = '{1, 0, 0, 0, 0,          8'h00, 0, 0, 1};
        vt[8]  = '{1, 1, 0, 0, 0,          8'h01, 1, 0, 1};
        vt[9]  = '{0, 1, 0, 1, 64'h800000, 8'h01, 0, 0, 0};
        vt[10] = '{1, 1, 0, 0, 0,          8'h02, 1, 0, 0};
        vt[11] = '{0, 1, 1, 0, 0,          8'h00, 0, 0, 1};
        vt[12] = '{1, 1, 0, 0, 0,          8'h80, 1, 0, 1};
        vt[13] = '{1, 1, 0, 0, 0,          8'h00, 1, 1, 1};

        ma = mdl_zero();
        mb = mdl_zero();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        foreach (vt[i]) begin
            tick = vt[i].tick; en = vt[i].en; sync_s = vt[i].sync;
            va = vt[i].valid; vb = vt[i].valid; data = 24'(vt[i].data);
            cycle();
            check("vec_phase", 64'(pa), 64'(vt[i].ph));
            check("vec_phase_valid", 64'(pva), 64'(vt[i].pv));
            check("vec_wrap", 64'(wa), 64'(vt[i].wr));
            check("vec_tw_ready", 64'(ra), 64'(vt[i].rdy));
        end
        tick = 0; en = 1; sync_s = 0; va = 0; vb = 0;

        do_reset();
        load_both(64'h010000);
        cycle();
        for (int k = 1; k <= 256; k++) begin
            tick_once();
            check("ramp_phase_a", 64'(pa), 64'(k & 255));
            check("ramp_wrap_a", 64'(wa), 64'(k == 256));
            check("ramp_phase_b", 64'(pb), 64'(k & 255));
            idle(3);
        end
        for (int k = 1; k <= 128; k++) begin
            tick_once();
            idle(3);
        end
        check("pre_load_phase", 64'(pa), 64'h80);

        load_both(64'h020000);
        va = 1; data = 24'h030000;
        check("load_ready_a", 64'(ra), 64'd0);
        for (int k = 1; k <= 128; k++) begin
            tick_once();
            check("at_wrap_phase_a", 64'(pa), 64'((8'h80 + k) & 255));
            check("at_tick_phase_b", 64'(pb), 64'((8'h80 + 2 * k) & 255));
            if (k < 128) begin
                check("stall_ready_a", 64'(ra), 64'd0);
                idle(3);
            end
        end
        check("apply_wrap_a", 64'(wa), 64'd1);
        check("apply_ready_a", 64'(ra), 64'd1);
        cycle();
        va = 0;
        check("second_accept_a", 64'(ra), 64'd0);
        idle(2);
        tick_once();
        check("new_step_a_1", 64'(pa), 64'h02);
        idle(3);
        tick_once();
        check("new_step_a_2", 64'(pa), 64'h04);
        idle(3);

        do_reset();
        load_both(64'h010000);
        cycle();
        for (int k = 0; k < 8'h37; k++) begin
            tick_once();
            idle(3);
        end
        check("sync_pre_phase", 64'(pa), 64'h37);
        sync_s = 1; tick = 1;
        cycle();
        sync_s = 0; tick = 0;
        check("sync_tick_phase", 64'(pa), 64'h00);
        check("sync_tick_valid", 64'(pva), 64'd1);
        check("sync_tick_wrap", 64'(wa), 64'd1);
        tick_once();
        tick_once();
        sync_s = 1;
        cycle();
        sync_s = 0;
        check("sync_only_phase", 64'(pa), 64'h00);
        check("sync_only_valid", 64'(pva), 64'd0);
        load_both(64'h050000);
        check("sync_full_ready", 64'(ra), 64'd0);
        sync_s = 1;
        cycle();
        sync_s = 0;
        check("sync_apply_ready_a", 64'(ra), 64'd1);
        check("sync_apply_ready_b", 64'(rb), 64'd1);
        tick_once();
        check("sync_new_step", 64'(pa), 64'h05);
        idle(3);

        held = int'(pa);
        en = 0;
        for (int k = 0; k < 10; k++) begin
            tick_once();
            check("disabled_phase", 64'(pa), 64'(held));
            check("disabled_valid", 64'(pva), 64'd0);
            idle(3);
        end
        en = 1;

        do_reset();
        for (int k = 0; k < 20; k++) begin
            tick_once();
            check("zero_tw_valid", 64'(pva), 64'd1);
            check("zero_tw_phase", 64'(pa), 64'd0);
            check("zero_tw_wrap", 64'(wa), 64'd0);
            idle(3);
        end

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            tick   = ($urandom % 3) == 0;
            en     = ($urandom % 10) != 0;
            sync_s = ($urandom % 40) == 0;
            va     = ($urandom % 5) == 0;
            vb     = ($urandom % 5) == 0;
            case ($urandom % 4)
                0: data = 24'($urandom);
                1: data = 24'($urandom & 32'h3FFFF);
                2: data = '0;
                default: data = 24'(32'h800000 | ($urandom & 32'h7FFFFF));
            endcase
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
